// File: rtl/lock_arb_pkg.sv
// ============================================================================
// Module  : lock_arb_pkg
// Brief   : Shared types, default constants and helpers for lock_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 17;

  // Returns the index of the set bit; input is expected to be one-hot (N <= 16).
  function automatic int onehot_to_idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lock_arbiter_prio_pick.sv
// ============================================================================
// Module  : prio_pick
// Brief   : Combinational first-one finder with a wrapping start index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   vec_i,
  input  logic [IDW-1:0] start_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  always_comb begin
    int j;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!found_o && vec_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lock_arbiter.sv
// ============================================================================
// Module  : lock_arbiter
// Brief   : N-requester locking arbiter with watchdog revocation and masking.
//           Define LOCK_ARB_ROUND_ROBIN_EN for rotating priority (default fixed).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_arbiter
  import lock_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int IDW     = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout,
  output logic [IDW-1:0] timeout_id
);

`ifdef LOCK_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

  state_t         state_q;
  logic [15:0]    wdog_q;
  logic [N-1:0]   mask_q;
  logic [IDW-1:0] last_q;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic           timeout_q;
  logic [IDW-1:0] timeout_id_q;

  logic [N-1:0]   pick_vec;
  logic [IDW-1:0] rr_start;
  logic [IDW-1:0] start_d;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_oh;
  logic           owner_req;
  logic [IDW-1:0] owner_idx;

  // Excluding the current owner makes a release re-arbitrate among the others.
  assign pick_vec  = REQ & ~mask_q & ~gnt_q;
  assign rr_start  = (last_q == IDW'(N - 1)) ? '0 : last_q + 1'b1;
  assign start_d   = ROUND_ROBIN ? rr_start : '0;
  assign owner_req = |(REQ & gnt_q);
  assign owner_idx = IDW'(onehot_to_idx(16'(gnt_q)));

  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  prio_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .vec_i   (pick_vec),
    .start_i (start_d),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      mask_q       <= '0;
      last_q       <= IDW'(N - 1);
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      mask_q    <= mask_q & REQ;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q    <= pick_oh;
            gnt_id_q <= pick_idx;
            last_q   <= pick_idx;
            wdog_q   <= '0;
            state_q  <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            wdog_q <= '0;
            if (pick_found) begin
              gnt_q    <= pick_oh;
              gnt_id_q <= pick_idx;
              last_q   <= pick_idx;
            end else begin
              gnt_q    <= '0;
              gnt_id_q <= '0;
              state_q  <= IDLE;
            end
          end else if (wdog_q == WDOG_LIMIT) begin
            // Revoked owner stays masked until it drops its request.
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            wdog_q       <= '0;
            timeout_q    <= 1'b1;
            timeout_id_q <= owner_idx;
            mask_q       <= (mask_q & REQ) | gnt_q;
            state_q      <= IDLE;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign gnt_valid  = |gnt_q;
  assign gnt_id     = gnt_id_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;

endmodule

`default_nettype wire

// File: doc/lock_arbiter.md
Name: lock_arbiter

Overview:
- Synchronous N-requester arbiter for a single shared resource. It is the parametrised successor of the two-unit priority arbiter.
- Once a grant is issued it is locked: a higher-priority request never pre-empts it.
- A built-in watchdog revokes a grant held longer than TIMEOUT cycles, so two units holding interlocking resources cannot deadlock.
- Instances are placed one per shared resource; requesters see only REQ/gnt.

Parameters:
- N, 4: number of requesters, 2..16.
- TIMEOUT, 17: maximum cycles a grant may be held before revocation, 2..65535.
- IDW, $clog2(N): width of the owner index.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  N  request level per requester; held high until the unit is done or gives up.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  OR of gnt.
- gnt_id  output  IDW  index of the current owner; 0 when idle.
- timeout  output  1  one-cycle pulse on the cycle a grant is revoked.
- timeout_id  output  IDW  index of the revoked owner; valid while timeout is high, held otherwise.

Behaviour:
- Reset (asynchronous, immediate): gnt=0, gnt_valid=0, gnt_id=0, timeout=0, timeout_id=0, state=IDLE, wdog=0, mask=0, last=N-1.
- An asserted RST mid-grant drops gnt immediately, with no timeout pulse.
- States: IDLE, OWNED.
- Eligible set: REQ & ~mask.
- IDLE:
  - If the eligible set is non-zero, pick a winner per the priority rule.
  - Next edge: gnt[winner]=1, gnt_id=winner, wdog=0, last=winner, state=OWNED.
  - Request-to-grant latency is 1 cycle.
- OWNED, owner's REQ high, wdog < TIMEOUT-1: hold the grant and increment wdog. Other requests are ignored (no pre-emption).
- OWNED, owner's REQ low (release):
  - gnt clears at the next edge; wdog=0.
  - At that same edge, re-arbitrate among the eligible set, excluding the releaser. This gives a back-to-back handover with zero idle cycles.
  - Go to OWNED if there is a winner, otherwise IDLE.
- OWNED, owner's REQ high, wdog == TIMEOUT-1 (revocation):
  - Next edge: gnt=0, timeout=1, timeout_id=owner, mask[owner]=1, state=IDLE.
  - A grant therefore lasts exactly TIMEOUT cycles.
  - Re-arbitration happens on the following cycle from IDLE.
- Mask clear: mask[i] clears on any edge where REQ[i] is sampled low. A revoked unit must drop REQ for at least one cycle before it is eligible again.
- Release and timeout in the same cycle (REQ falls on the wdog==TIMEOUT-1 cycle): release wins; no timeout pulse, no mask.
- Simultaneous requests in IDLE: exactly one winner. gnt is never multi-hot.
- A REQ pulse shorter than one cycle between edges is not seen; REQ is sampled synchronously only.

Optional Feature:
- LOCK_ARB_ROUND_ROBIN_EN defined: rotating priority. The search starts at index (last+1) mod N and wraps. last updates on every grant.
- Undefined: fixed priority, lowest index wins. The last register is still present but unused.
- Lock, watchdog and mask behaviour are identical in both builds.

Decomposition:
- Package lock_arb_pkg holds:
  - the state enum (IDLE, OWNED);
  - the default TIMEOUT constant (17);
  - a function onehot_to_idx.
- One sub-module, prio_pick: a combinational first-one finder over an N-bit vector with a start index input.
  - Outputs: found and idx.
  - Fixed-priority builds tie the start index to 0.

Test Plan:
1. N=4, TIMEOUT=17. REQ=0110 rises at t0 → gnt=0010 at the t0+1 edge, gnt_id=1. REQ[2] stays waiting, no pre-emption, while REQ[1] is held for 5 cycles. REQ[1] falls → gnt=0100 at the next edge, with no idle cycle.
2. Lock: REQ[3] is granted alone, then REQ[0] rises → gnt stays 1000 until REQ[3] falls. gnt then becomes 0001 in the fixed build.
3. Watchdog:
   - REQ[2] is held high continuously → gnt[2] high for exactly 17 cycles, then gnt=0, timeout=1 for one cycle, timeout_id=2.
   - REQ[2] remains high → no regrant.
   - REQ[2] is dropped for 1 cycle and re-raised → granted 1 cycle after re-raise.
4. Release-at-timeout: REQ[1] falls on the 17th granted cycle → no timeout pulse. REQ[1] re-raised immediately → eligible.
5. Round robin (LOCK_ARB_ROUND_ROBIN_EN): REQ=1111 held, each owner releases after 2 cycles → grant order 0,1,2,3,0. Fixed build under the same stimulus: 0,1,2,3, then 0 only when REQ[0] is re-asserted.
6. Reset mid-grant: RST pulses while gnt=0100 → gnt=0 asynchronously, no timeout pulse, mask cleared. After release, REQ=0100 is regranted 1 cycle later.
